// File: rtl/switch_debounce_ctrl.sv
// switch_debounce_ctrl: Avalon-MM slave that synchronizes and debounces board
// switches, latches debounced transitions into a W1C edge-capture register and
// raises a maskable level interrupt.
// Optional build macro SWITCH_DEBOUNCE_BYPASS_EN adds a bypass bit (reg 3 bit 16)
// that forwards the synchronized inputs straight to the debounced state.
//
// Register map (32-bit, unused bits read 0):
//   0: debounced state (RO)   1: irq mask (RW)
//   2: edge capture (W1C)     3: prescale[15:0] (RW), bypass[16] when enabled
module switch_debounce_ctrl #(
    parameter int unsigned WIDTH            = 10,
    parameter int unsigned STABLE_SAMPLES   = 4,
    parameter logic [15:0] PRESCALE_DEFAULT = 16'd49999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned PRE_W      = 16;
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_SAMPLES);

    localparam logic [1:0] ADDR_DEB   = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_PRESC = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [PRE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             bypass_q, bypass_d;

    logic             wr_c;
    logic             wr_presc_c;
    logic             tick_c;
    logic             unused_wdata_c;

    assign wr_c           = chipselect & ~write_n;
    assign wr_presc_c     = wr_c && (address == ADDR_PRESC);
    assign unused_wdata_c = ^writedata;

    // Sample tick: counter runs 0..prescale; a prescale write restarts it without a tick
    always_comb begin
        tick_c     = 1'b0;
        pcnt_d     = pcnt_q + PRE_W'(1);
        prescale_d = prescale_q;
        bypass_d   = bypass_q;
        if (wr_presc_c) begin
            pcnt_d     = '0;
            prescale_d = writedata[PRE_W-1:0];
`ifdef SWITCH_DEBOUNCE_BYPASS_EN
            bypass_d   = writedata[16];
`endif
        end else if (pcnt_q == prescale_q) begin
            tick_c = 1'b1;
            pcnt_d = '0;
        end
    end

    // Per-bit debounce: a new level must survive STABLE_SAMPLES consecutive ticks
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (bypass_q) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else if (tick_c) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if ((cnt_q[i] + CNT_W'(1)) == STABLE_CNT) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Mask write, W1C edge capture (a new edge beats a simultaneous clear), irq
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr_c && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_c && (address == ADDR_EDGE)) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        edge_d = edge_d | (deb_d ^ deb_q);
        irq_d  = |(edge_q & mask_q);
    end

    // Read mux, registered every cycle for a fixed one-cycle read latency
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DEB:   readdata_d = 32'(deb_q);
            ADDR_MASK:  readdata_d = 32'(mask_q);
            ADDR_EDGE:  readdata_d = 32'(edge_q);
            ADDR_PRESC: readdata_d = {15'd0, bypass_q, prescale_q};
            default:    readdata_d = '0;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            prescale_q <= PRESCALE_DEFAULT;
            pcnt_q     <= '0;
            bypass_q   <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            bypass_q   <= bypass_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl: expected values go into a scoreboard
// queue when stimulus is issued and are popped when the DUT output is sampled.
module tb_switch_debounce_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    logic [31:0] sb[$];
    int          total;
    int          bad;

    switch_debounce_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with the observed value
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=0x%08h, scoreboard empty", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
            end
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb.push_back(exp);
        check(tag, obs);
    endtask

    // Called at a negedge; presents a write for exactly one posedge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        write_n   = 1'b1;
    endtask

    // Called at a negedge; readdata is valid at the following negedge
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        check(tag, readdata);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        logic early;

        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        expect_val("rst_irq", 32'(irq), 32'd0);
        expect_val("rst_rdata", readdata, 32'd0);
        rd(2'd0, 32'h0, "rst_reg0");
        rd(2'd1, 32'h0, "rst_reg1");
        rd(2'd2, 32'h0, "rst_reg2");
        rd(2'd3, 32'h0000C34F, "rst_reg3");

        // Clean debounce with prescale=3
        wr(2'd3, 32'd3);
        in_port = 10'h001;
        address = 2'd0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            n = k;
            if (readdata[0]) break;
        end
        expect_val("deb_window", 32'((n - 1 >= 14) && (n - 1 <= 19)), 32'd1);
        rd(2'd0, 32'h001, "clean_reg0");
        rd(2'd2, 32'h001, "clean_reg2");
        expect_val("clean_irq_masked", 32'(irq), 32'd0);
        wr(2'd2, 32'h001);
        rd(2'd2, 32'h000, "w1c_clear");

        // Glitch shorter than four ticks is rejected
        in_port = 10'h021;
        repeat (10) @(negedge clk);
        in_port = 10'h001;
        repeat (30) @(negedge clk);
        rd(2'd0, 32'h001, "glitch_reg0");
        rd(2'd2, 32'h000, "glitch_reg2");
        expect_val("glitch_irq", 32'(irq), 32'd0);

        // Interrupt path on bit 9
        wr(2'd1, 32'h200);
        in_port = 10'h201;
        address = 2'd2;
        seen  = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (readdata[9]) begin
                seen = 1'b1;
                break;
            end
            early = early | irq;
        end
        expect_val("edge9_set", 32'(seen), 32'd1);
        expect_val("irq_not_early", 32'(early), 32'd0);
        expect_val("irq_rise", 32'(irq), 32'd1);
        wr(2'd2, 32'h200);
        expect_val("irq_hold", 32'(irq), 32'd1);
        @(posedge clk);
        @(negedge clk);
        expect_val("irq_clear", 32'(irq), 32'd0);

        // Masked edge on bit 0 does not interrupt
        in_port = 10'h200;
        address = 2'd2;
        seen  = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            early = early | irq;
            if (readdata[0]) begin
                seen = 1'b1;
                break;
            end
        end
        expect_val("edge0_set", 32'(seen), 32'd1);
        expect_val("edge0_irq_masked", 32'(early), 32'd0);

        // Prescale rewrite to 0 mid-count: tick every cycle
        repeat (2) @(negedge clk);
        wr(2'd3, 32'd0);
        in_port = 10'h208;
        address = 2'd0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            n = k;
            if (readdata[3]) break;
        end
        expect_val("fast_accept", 32'(n), 32'd7);

        // Set/clear collision on bit 2
        wr(2'd2, 32'h3FF);
        rd(2'd2, 32'h000, "collide_pre");
        in_port = 10'h20C;
        repeat (5) @(negedge clk);
        wr(2'd2, 32'h004);
        rd(2'd2, 32'h004, "collide_set_wins");
        rd(2'd0, 32'h20C, "collide_reg0");

        // Register access corners
        rd(2'd1, 32'h200, "mask_rb");
        wr(2'd0, 32'hFFFF);
        rd(2'd0, 32'h20C, "reg0_ro");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h3FF, "mask_unused_bits");
        wr(2'd1, 32'h0);
        wr(2'd3, 32'hFFFE_0005);
        rd(2'd3, 32'h0000_0005, "presc_rb");
`ifdef SWITCH_DEBOUNCE_BYPASS_EN
        wr(2'd3, 32'h0001_0005);
        rd(2'd3, 32'h0001_0005, "bypass_rb");
        in_port = 10'h20D;
        repeat (4) @(negedge clk);
        rd(2'd0, 32'h20D, "bypass_deb");
        in_port = 10'h20C;
        repeat (4) @(negedge clk);
        wr(2'd3, 32'h0000_0005);
`endif

        // Reset mid-debounce, then re-qualify held switches
        in_port = 10'h20D;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd3, 32'h0000C34F, "rst2_reg3");
        rd(2'd0, 32'h000, "rst2_reg0");
        rd(2'd2, 32'h000, "rst2_reg2");
        wr(2'd3, 32'd0);
        repeat (20) @(negedge clk);
        rd(2'd0, 32'h20D, "requal_reg0");
        rd(2'd2, 32'h20D, "requal_reg2");
        expect_val("requal_irq", 32'(irq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
